// File: rtl/packetizer_pkg.sv
// packetizer_pkg: shared constants, FSM states and the sample-pair record
package packetizer_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         SEQ_WIDTH = 7;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        CH0,
        CH1
    } state_t;

    // Both channels are stored already zero-extended to the stream width.
    typedef struct packed {
        logic [15:0] ch0;
        logic [15:0] ch1;
    } sample_pair_t;

endpackage

// File: rtl/axis_interface.sv
// axis_interface: AXI-Stream bundle with source and sink views
interface axis_interface #(
    parameter int DATA_WIDTH = 16
);

    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic                    tid;
    logic                    tdest;
    logic                    tuser;

    modport Source (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
    modport Sink   (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);

endinterface

// File: rtl/sample_pair_fifo.sv
// sample_pair_fifo: synchronous first-word-fall-through FIFO of sample pairs
//   wr_en/wr_data : push (caller guarantees !full)
//   rd_en         : pop the head (caller guarantees !empty)
//   rd_data       : current head; rd_next : entry behind the head
//   count/full/empty : derived from the registered fill count
module sample_pair_fifo
    import packetizer_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  sample_pair_t           wr_data,
    input  logic                   rd_en,
    output sample_pair_t           rd_data,
    output sample_pair_t           rd_next,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    sample_pair_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign rd_next = mem_q[rd_ptr_q + AW'(1)];
    assign count   = count_q;
    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;

endmodule

// File: rtl/adc_sample_packetizer.sv
// adc_sample_packetizer: packs two-channel ADC sample pairs into headered AXI-Stream packets
//   clk, rst      : sole clock, synchronous active-high reset
//   sample_valid  : a pair is presented this cycle (no backpressure)
//   ch0/ch1_sample: channel samples, zero-extended to 16 bits on output
//   packet_stream : 16-bit source; header {A5, overflow, seq}, then ch0/ch1 per pair, tlast on last ch1
module adc_sample_packetizer
    import packetizer_pkg::*;
#(
    parameter int SAMPLE_WIDTH       = 14,
    parameter int SAMPLES_PER_PACKET = 32,
    parameter int FIFO_DEPTH         = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] ch0_sample,
    input  logic [SAMPLE_WIDTH-1:0] ch1_sample,
    axis_interface.Source           packet_stream
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = $clog2(SAMPLES_PER_PACKET + 1);

    state_t               state_q, state_d;
    logic [SEQ_WIDTH-1:0] seq_q, seq_d;
    logic                 ovf_q, ovf_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [15:0]          tdata_q, tdata_d;
    logic                 tlast_q, tlast_d;

    logic [CW-1:0] fill;
    logic          full, empty, wr_en, drop, pop;
    logic          tvalid, hs, start, last_pair;
    sample_pair_t  head, nxt;

    assign wr_en     = sample_valid && !full;
    assign drop      = sample_valid && full;
    assign tvalid    = state_q != IDLE;
    assign hs        = tvalid && packet_stream.tready;
    assign start     = state_q == IDLE && fill >= CW'(SAMPLES_PER_PACKET);
    assign last_pair = idx_q == IW'(SAMPLES_PER_PACKET - 1);
    assign pop       = state_q == CH1 && hs && !empty;

    sample_pair_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_data('{ch0: 16'(ch0_sample), ch1: 16'(ch1_sample)}),
        .rd_en  (pop),
        .rd_data(head),
        .rd_next(nxt),
        .count  (fill),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            tdata_q <= '0;
            tlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
            tdata_q <= tdata_d;
            tlast_q <= tlast_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? HEADER : IDLE;
            HEADER:  state_d = hs ? CH0 : HEADER;
            CH0:     state_d = hs ? CH1 : CH0;
            CH1:     state_d = hs ? (last_pair ? IDLE : CH0) : CH1;
            default: state_d = IDLE;
        endcase
    end

    // tdata is preloaded on the handshake edge; the word after a ch1 comes
    // from the entry behind the head because the head is popped on that edge.
    always_comb begin
        seq_d   = start ? seq_q + SEQ_WIDTH'(1) : seq_q;
        ovf_d   = drop || (ovf_q && !start);
        idx_d   = pop ? (last_pair ? '0 : idx_q + IW'(1)) : idx_q;
        tdata_d = start                ? {SYNC_BYTE, ovf_q, seq_q} :
                  !hs                  ? tdata_q :
                  state_q == HEADER    ? head.ch0 :
                  state_q == CH0       ? head.ch1 :
                  last_pair            ? tdata_q : nxt.ch0;
        tlast_d = (hs && state_q == CH0) ? last_pair :
                  (hs && state_q == CH1) ? 1'b0 : tlast_q;
    end

    assign packet_stream.tvalid = tvalid;
    assign packet_stream.tdata  = tdata_q;
    assign packet_stream.tlast  = tlast_q;
    assign packet_stream.tkeep  = '1;
    assign packet_stream.tid    = 1'b0;
    assign packet_stream.tdest  = 1'b0;
    assign packet_stream.tuser  = 1'b0;

endmodule

// File: tb/tb_adc_sample_packetizer.sv
// tb_adc_sample_packetizer: randomized self-checking bench with a queue-based packet model
module tb_adc_sample_packetizer;

    localparam int SW = 14;
    localparam int N  = 4;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_valid = 1'b0;
    logic [SW-1:0] ch0 = '0;
    logic [SW-1:0] ch1 = '0;

    axis_interface #(.DATA_WIDTH(16)) axis ();

    adc_sample_packetizer #(
        .SAMPLE_WIDTH      (SW),
        .SAMPLES_PER_PACKET(N),
        .FIFO_DEPTH        (D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .ch0_sample   (ch0),
        .ch1_sample   (ch1),
        .packet_stream(axis)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int pkts     = 0;
    int accepted = 0;

    // Reference model: pairs resident in the FIFO, word position in the
    // current packet, next sequence number and pending overflow flag.
    logic [15:0] mq0[$];
    logic [15:0] mq1[$];
    logic [16:0] got[$];
    logic [15:0] hdrs[$];
    int          pos = 0;
    logic [6:0]  seq = '0;
    bit          pend = 0, last_drop = 0, hdr_flag = 0;
    bit          prev_tv = 0, prev_stall = 0, prev_rst = 1, prev_last = 0;
    logic [15:0] prev_data = '0;

    always @(negedge clk) begin
        bit          tv, hs, push;
        logic [15:0] exp;
        tv = axis.tvalid;
        if (prev_rst) begin
            n_checks++;
            if ({tv, axis.tlast, axis.tdata} !== 18'h0)
                $display("FAIL reset_outputs: tvalid=%b tlast=%b tdata=%h, want 0 0 0000", tv, axis.tlast, axis.tdata);
            else n_pass++;
        end else begin
            if (tv && !prev_tv) begin
                hdr_flag = pend;
                pend     = last_drop;
            end else pend = pend | last_drop;
            if (prev_stall) begin
                n_checks++;
                if ({tv, axis.tdata, axis.tlast} !== {1'b1, prev_data, prev_last})
                    $display("FAIL stall_hold: tvalid=%b tdata=%h tlast=%b, want 1 %h %b", tv, axis.tdata, axis.tlast, prev_data, prev_last);
                else n_pass++;
            end
            if (pos != 0) begin
                n_checks++;
                if (tv !== 1'b1) $display("FAIL no_gap: tvalid=%b at word %0d, want 1", tv, pos);
                else n_pass++;
            end
            if (tv) begin
                n_checks++;
                if (pos != 0 && mq0.size() == 0) begin
                    $display("FAIL unexpected_word: tdata=%h with no pair resident, want none", axis.tdata);
                end else begin
                    exp = pos == 0 ? {8'hA5, hdr_flag, seq} : (pos % 2 == 1 ? mq0[0] : mq1[0]);
                    if ({axis.tdata, axis.tlast} !== {exp, pos == 2 * N})
                        $display("FAIL word_%0d: tdata=%h tlast=%b, want %h %b", pos, axis.tdata, axis.tlast, exp, pos == 2 * N);
                    else n_pass++;
                end
            end
        end
        hs         = tv && axis.tready && !rst;
        prev_stall = tv && !axis.tready && !rst;
        prev_data  = axis.tdata;
        prev_last  = axis.tlast;
        prev_tv    = tv;
        prev_rst   = rst;
        if (rst) begin
            mq0.delete();
            mq1.delete();
            pos = 0; seq = '0; pend = 0; last_drop = 0; hdr_flag = 0;
        end else begin
            last_drop = sample_valid && mq0.size() == D;
            push      = sample_valid && mq0.size() < D;
            if (hs) begin
                got.push_back({axis.tlast, axis.tdata});
                if (pos == 0) begin
                    hdrs.push_back(axis.tdata);
                    seq++;
                    pos++;
                end else if (pos % 2 == 1) pos++;
                else begin
                    void'(mq0.pop_front());
                    void'(mq1.pop_front());
                    if (pos == 2 * N) begin
                        pos = 0;
                        pkts++;
                    end else pos++;
                end
            end
            if (push) begin
                mq0.push_back(16'(ch0));
                mq1.push_back(16'(ch1));
                accepted++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [SW-1:0] a, input logic [SW-1:0] b);
        ch0 = a;
        ch1 = b;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_pkts(input int target, input int budget);
        for (int c = 0; c < budget && pkts < target; c++) tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({axis.tvalid, axis.tlast, axis.tdata} !== 18'h0)
            $display("FAIL rst_state: tvalid=%b tlast=%b tdata=%h, want 0 0 0000", axis.tvalid, axis.tlast, axis.tdata);
        else n_pass++;
        n_checks++;
        if ({axis.tkeep, axis.tid, axis.tdest, axis.tuser} !== 5'b11000)
            $display("FAIL sideband: tkeep=%b tid=%b tdest=%b tuser=%b, want 11 0 0 0", axis.tkeep, axis.tid, axis.tdest, axis.tuser);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_first_packet;
        logic [15:0] w[9];
        int base;
        w = '{16'hA500, 16'h0001, 16'h1001, 16'h0002, 16'h1002, 16'h0003, 16'h1003, 16'h0004, 16'h1004};
        axis.tready = 1'b1;
        got.delete();
        base = pkts;
        for (int i = 1; i <= 4; i++) feed(SW'(i), SW'(16'h1000 + i));
        n_checks++;
        if (axis.tvalid !== 1'b0) $display("FAIL hdr_latency_early: tvalid=%b after 4th write edge, want 0", axis.tvalid);
        else n_pass++;
        tick();
        n_checks++;
        if ({axis.tvalid, axis.tdata} !== {1'b1, 16'hA500})
            $display("FAIL hdr_latency: tvalid=%b tdata=%h one edge later, want 1 a500", axis.tvalid, axis.tdata);
        else n_pass++;
        wait_pkts(base + 1, 40);
        n_checks++;
        if (got.size() != 9) $display("FAIL first_len: %0d words, want 9", got.size());
        else begin
            n_pass++;
            for (int i = 0; i < 9; i++) begin
                n_checks++;
                if (got[i] !== {i == 8, w[i]})
                    $display("FAIL first_word_%0d: got %h, want %h", i, got[i], {i == 8, w[i]});
                else n_pass++;
            end
        end
    endtask

    task automatic test_seq_wrap;
        int base;
        hdrs.delete();
        base = pkts;
        for (int p = 0; p < 129; p++) begin
            for (int i = 0; i < N; i++) feed(SW'($urandom), SW'($urandom));
            wait_pkts(base + p + 1, 40);
        end
        n_checks++;
        if (hdrs.size() != 129) $display("FAIL wrap_count: %0d headers, want 129", hdrs.size());
        else begin
            n_pass++;
            for (int p = 0; p < 129; p++) begin
                n_checks++;
                if (hdrs[p] !== {8'hA5, 1'b0, 7'(p + 1)})
                    $display("FAIL wrap_hdr_%0d: got %h, want %h", p, hdrs[p], {8'hA5, 1'b0, 7'(p + 1)});
                else n_pass++;
            end
        end
    endtask

    task automatic test_overflow;
        int  base;
        bit  seen;
        axis.tready = 1'b0;
        hdrs.delete();
        base = pkts;
        for (int i = 0; i < 12; i++) feed(SW'($urandom), SW'($urandom));
        axis.tready = 1'b1;
        wait_pkts(base + 2, 60);
        seen = 0;
        repeat (12) begin
            tick();
            seen |= axis.tvalid;
        end
        n_checks++;
        if (pkts != base + 2 || seen) $display("FAIL ovf_stored: %0d packets, extra tvalid=%b, want 2 packets and 0", pkts - base, seen);
        else n_pass++;
        for (int i = 0; i < N; i++) feed(SW'($urandom), SW'($urandom));
        wait_pkts(base + 3, 40);
        n_checks++;
        if (hdrs.size() != 3) $display("FAIL ovf_hdrs: %0d headers, want 3", hdrs.size());
        else begin
            n_pass++;
            n_checks++;
            if ({hdrs[0][7], hdrs[1][7], hdrs[2][7]} !== 3'b010)
                $display("FAIL ovf_flag: flags %b%b%b, want 010", hdrs[0][7], hdrs[1][7], hdrs[2][7]);
            else n_pass++;
        end
    endtask

    task automatic test_random_ready;
        int base, acc0;
        base = pkts;
        acc0 = accepted;
        for (int c = 0; c < 4000 && pkts < base + 20; c++) begin
            axis.tready  = 1'($urandom);
            sample_valid = (accepted - acc0 < 20 * N) && 1'($urandom);
            ch0 = SW'($urandom);
            ch1 = SW'($urandom);
            tick();
        end
        sample_valid = 1'b0;
        axis.tready  = 1'b1;
        n_checks++;
        if (pkts != base + 20) $display("FAIL random_pkts: %0d packets, want 20", pkts - base);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int base;
        axis.tready = 1'b1;
        for (int i = 0; i < N; i++) feed(SW'($urandom), SW'($urandom));
        for (int c = 0; c < 10 && !axis.tvalid; c++) tick();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({axis.tvalid, axis.tlast} !== 2'b00)
            $display("FAIL mid_reset: tvalid=%b tlast=%b, want 0 0", axis.tvalid, axis.tlast);
        else n_pass++;
        rst = 1'b0;
        hdrs.delete();
        base = pkts;
        for (int i = 0; i < N; i++) feed(SW'($urandom), SW'($urandom));
        wait_pkts(base + 1, 40);
        n_checks++;
        if (pkts != base + 1 || hdrs.size() != 1 || hdrs[0] !== 16'hA500)
            $display("FAIL post_reset_pkt: %0d packets, header %h, want 1 a500", pkts - base, hdrs.size() ? hdrs[0] : 16'h0);
        else n_pass++;
    endtask

    task automatic test_partial;
        int base;
        bit seen;
        base = pkts;
        seen = 0;
        for (int i = 0; i < N - 1; i++) feed(SW'($urandom), SW'($urandom));
        repeat (20) begin
            tick();
            seen |= axis.tvalid;
        end
        n_checks++;
        if (seen) $display("FAIL partial_idle: tvalid seen with %0d pairs, want none", N - 1);
        else n_pass++;
        feed(SW'($urandom), SW'($urandom));
        wait_pkts(base + 1, 40);
        n_checks++;
        if (pkts != base + 1) $display("FAIL partial_trigger: %0d packets, want 1", pkts - base);
        else n_pass++;
    endtask

    initial begin
        axis.tready = 1'b0;
        test_reset();
        test_first_packet();
        test_seq_wrap();
        test_overflow();
        test_random_ready();
        test_reset_mid();
        test_partial();
        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
